// File: rtl/drv_switch_array_if.sv
// Switch-bank bus: raw pins in, debounced levels, event pulses and click encoder out.
interface drv_switch_array_if #(
    parameter int p_width = 4
);
    localparam int c_code_w = (p_width > 1) ? $clog2(p_width) : 1;

    logic [p_width-1:0]  i_drv_sw;
    logic [p_width-1:0]  o_press;
    logic [p_width-1:0]  o_click;
    logic [p_width-1:0]  o_release;
    logic [p_width-1:0]  o_long;
    logic [p_width-1:0]  o_repeat;
    logic [p_width-1:0]  o_toggle;
    logic                o_toggle_common;
    logic [c_code_w-1:0] o_code;
    logic                o_code_valid;

    modport master (
        output i_drv_sw,
        input  o_press, o_click, o_release, o_long, o_repeat, o_toggle,
        input  o_toggle_common, o_code, o_code_valid
    );

    modport slave (
        input  i_drv_sw,
        output o_press, o_click, o_release, o_long, o_repeat, o_toggle,
        output o_toggle_common, o_code, o_code_valid
    );
endinterface

// File: rtl/drv_switch_array.sv
// Debounced switch bank: shared tick prescaler, per-channel debounce + press FSM
// (click/release/long/repeat/toggle), toggle OR and lowest-index click encoder.
module drv_switch_lane #(
    parameter string p_mode   = "pullup",
    parameter int    p_stable = 3,
    parameter int    p_long   = 64,
    parameter int    p_repeat = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_tick,
    input  logic i_sw,
    output logic o_press,
    output logic o_click,
    output logic o_release,
    output logic o_long,
    output logic o_repeat,
    output logic o_toggle
);
    localparam logic c_rel    = (p_mode == "pullup") ? 1'b1 : 1'b0;
    localparam int   c_stab_w = $clog2(p_stable + 1);
    localparam int   c_hold_w = $clog2(p_long + 1);
    localparam int   c_rep_w  = $clog2(p_repeat + 1);

    typedef enum logic [1:0] {st_idle, st_held, st_long} state_t;

    state_t              state, state_nxt;
    logic [1:0]          sync;
    logic                sample;
    logic [c_stab_w-1:0] stab, stab_nxt;
    logic [c_hold_w-1:0] hold, hold_nxt;
    logic [c_rep_w-1:0]  rep, rep_nxt;
    logic press_nxt, click_nxt, release_nxt, long_nxt, repeat_nxt;

    // XOR with the released level turns either polarity into pressed=1
    assign sample = sync[1] ^ c_rel;

    always_comb begin
        state_nxt   = state;
        stab_nxt    = stab;
        hold_nxt    = hold;
        rep_nxt     = rep;
        press_nxt   = o_press;
        click_nxt   = 1'b0;
        release_nxt = 1'b0;
        long_nxt    = 1'b0;
        repeat_nxt  = 1'b0;

        if (i_tick) begin
            if (sample != o_press) begin
                if (stab == c_stab_w'(p_stable - 1)) begin
                    stab_nxt  = '0;
                    press_nxt = ~o_press;
                end else begin
                    stab_nxt = stab + c_stab_w'(1);
                end
            end else begin
                stab_nxt = '0;
            end
        end

        case (state)
            st_idle: if (press_nxt && !o_press) begin
                click_nxt = 1'b1;
                state_nxt = st_held;
                hold_nxt  = '0;
            end
            st_held: if (i_tick) begin
                if (hold == c_hold_w'(p_long - 1)) begin
                    long_nxt  = 1'b1;
                    state_nxt = st_long;
                    hold_nxt  = '0;
                    rep_nxt   = '0;
                end else begin
                    hold_nxt = hold + c_hold_w'(1);
                end
            end
            st_long: if (i_tick) begin
                if (rep == c_rep_w'(p_repeat - 1)) begin
                    repeat_nxt = 1'b1;
                    rep_nxt    = '0;
                end else begin
                    rep_nxt = rep + c_rep_w'(1);
                end
            end
            default: state_nxt = st_idle;
        endcase

        // Release overrides any long/repeat event landing on the same tick
        if (!press_nxt && o_press) begin
            release_nxt = 1'b1;
            long_nxt    = 1'b0;
            repeat_nxt  = 1'b0;
            state_nxt   = st_idle;
            hold_nxt    = '0;
            rep_nxt     = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state <= st_idle;
        else        state <= state_nxt;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            sync      <= {2{c_rel}};
            stab      <= '0;
            hold      <= '0;
            rep       <= '0;
            o_press   <= 1'b0;
            o_click   <= 1'b0;
            o_release <= 1'b0;
            o_long    <= 1'b0;
            o_repeat  <= 1'b0;
            o_toggle  <= 1'b0;
        end else begin
            sync      <= {sync[0], i_sw};
            stab      <= stab_nxt;
            hold      <= hold_nxt;
            rep       <= rep_nxt;
            o_press   <= press_nxt;
            o_click   <= click_nxt;
            o_release <= release_nxt;
            o_long    <= long_nxt;
            o_repeat  <= repeat_nxt;
            o_toggle  <= o_toggle ^ click_nxt;
        end
    end
endmodule

module drv_switch_array #(
    parameter int    p_width  = 4,
    parameter int    p_scale  = 5,
    parameter string p_mode   = "pullup",
    parameter int    p_stable = 3,
    parameter int    p_long   = 64,
    parameter int    p_repeat = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    drv_switch_array_if.slave   bus
);
    localparam int c_code_w = (p_width > 1) ? $clog2(p_width) : 1;

    logic [p_scale-1:0]  pre_cnt;
    logic                tick;
    logic [p_width-1:0]  press, click, rel, lng, rpt, tgl;
    logic                tgl_common;
    logic [c_code_w-1:0] code;

    assign tick = &pre_cnt;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            pre_cnt    <= '0;
            tgl_common <= 1'b0;
        end else begin
            pre_cnt    <= pre_cnt + p_scale'(1);
            tgl_common <= |tgl;
        end
    end

    for (genvar g = 0; g < p_width; g++) begin : g_lane
        drv_switch_lane #(
            .p_mode(p_mode), .p_stable(p_stable), .p_long(p_long), .p_repeat(p_repeat)
        ) u_lane (
            .i_clk    (i_clk),
            .i_rst    (i_rst),
            .i_tick   (tick),
            .i_sw     (bus.i_drv_sw[g]),
            .o_press  (press[g]),
            .o_click  (click[g]),
            .o_release(rel[g]),
            .o_long   (lng[g]),
            .o_repeat (rpt[g]),
            .o_toggle (tgl[g])
        );
    end

    // Scan high to low so the lowest clicked index is the last write
    always_comb begin
        code = '0;
        for (int i = p_width - 1; i >= 0; i--) begin
            if (click[i]) code = c_code_w'(i);
        end
    end

    assign bus.o_press         = press;
    assign bus.o_click         = click;
    assign bus.o_release       = rel;
    assign bus.o_long          = lng;
    assign bus.o_repeat        = rpt;
    assign bus.o_toggle        = tgl;
    assign bus.o_toggle_common = tgl_common;
    assign bus.o_code          = code;
    assign bus.o_code_valid    = |click;
endmodule

// File: tb/tb_drv_switch_array.sv
// Bench for drv_switch_array: directed corner sequences, a pulse-count vector table
// and random pin activity, all compared against a tick-counting reference model.
module tb_drv_switch_array;
    localparam int P_STABLE = 3;
    localparam int P_LONG   = 8;
    localparam int P_REPEAT = 4;

    logic i_clk = 1'b0;
    logic i_rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;

    drv_switch_array_if #(.p_width(4)) bus();

    drv_switch_array #(
        .p_width(4), .p_scale(2), .p_mode("pullup"),
        .p_stable(P_STABLE), .p_long(P_LONG), .p_repeat(P_REPEAT)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .bus  (bus)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: raw pin history, tick = every 4th clock after reset,
    // press flips after P_STABLE consecutive differing tick samples, events
    // derived from the number of ticks elapsed since the click.
    logic [3:0] m_h1, m_h2, m_press, m_click, m_rel, m_long, m_rep, m_tgl;
    logic       m_common;
    int         m_cyc;
    int         run_len [4];
    int         since   [4];
    bit         holding [4];

    always @(posedge i_clk or negedge i_rst) begin : model
        logic [3:0] samp;
        bit tick, flipped;
        if (!i_rst) begin
            m_h1 = 4'hF; m_h2 = 4'hF; m_cyc = 0;
            {m_press, m_click, m_rel, m_long, m_rep, m_tgl} = '0;
            m_common = 1'b0;
            for (int c = 0; c < 4; c++) begin run_len[c] = 0; since[c] = 0; holding[c] = 0; end
        end else begin
            samp = ~m_h2;
            tick = (m_cyc % 4) == 3;
            m_cyc++;
            m_common = |m_tgl;
            m_h2 = m_h1;
            m_h1 = bus.i_drv_sw;
            {m_click, m_rel, m_long, m_rep} = '0;
            for (int c = 0; c < 4; c++) begin
                flipped = 0;
                if (tick) begin
                    run_len[c] = (samp[c] != m_press[c]) ? run_len[c] + 1 : 0;
                    if (run_len[c] == P_STABLE) begin
                        run_len[c] = 0;
                        flipped = 1;
                        m_press[c] = ~m_press[c];
                        if (m_press[c]) begin
                            m_click[c] = 1; m_tgl[c] = ~m_tgl[c]; holding[c] = 1; since[c] = 0;
                        end else begin
                            m_rel[c] = 1; holding[c] = 0;
                        end
                    end
                end
                if (!flipped && holding[c] && tick) begin
                    since[c]++;
                    if (since[c] == P_LONG) m_long[c] = 1;
                    if (since[c] > P_LONG && (since[c] - P_LONG) % P_REPEAT == 0) m_rep[c] = 1;
                end
            end
        end
    end

    always @(negedge i_clk) begin
        int ec;
        if (chk_en) begin
            ec = 0;
            for (int c = 3; c >= 0; c--) if (m_click[c]) ec = c;
            chk("model_press",   bus.o_press,   m_press);
            chk("model_click",   bus.o_click,   m_click);
            chk("model_release", bus.o_release, m_rel);
            chk("model_long",    bus.o_long,    m_long);
            chk("model_repeat",  bus.o_repeat,  m_rep);
            chk("model_toggle",  bus.o_toggle,  m_tgl);
            chk("model_common",  bus.o_toggle_common, m_common);
            chk("model_code",    bus.o_code,    ec);
            chk("model_valid",   bus.o_code_valid, |m_click);
        end
    end

    // Pulse tallies per channel; cleared 1ns after a falling edge
    int n_click [4], n_long [4], n_rep [4], n_rel [4];
    always @(negedge i_clk) begin
        for (int c = 0; c < 4; c++) begin
            n_click[c] += bus.o_click[c];
            n_long[c]  += bus.o_long[c];
            n_rep[c]   += bus.o_repeat[c];
            n_rel[c]   += bus.o_release[c];
        end
    end

    task automatic clear_counts();
        #1;
        for (int c = 0; c < 4; c++) begin n_click[c] = 0; n_long[c] = 0; n_rep[c] = 0; n_rel[c] = 0; end
    endtask

    function automatic logic sig(input int kind, input int ch);
        case (kind)
            0:       return bus.o_click[ch];
            1:       return bus.o_long[ch];
            2:       return bus.o_release[ch];
            default: return bus.o_repeat[ch];
        endcase
    endfunction

    task automatic wait_pulse(input int kind, input int ch, input int bound, input string name);
        bit seen = 0;
        for (int k = 0; k < bound && !seen; k++) begin
            @(negedge i_clk);
            seen = sig(kind, ch);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: no pulse on ch%0d within %0d cycles", name, ch, bound);
        end
    endtask

    typedef struct {
        logic [3:0] mask;
        int dur, e_click, e_long, e_rep;
    } vec_t;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [7];
        int n, r0;
        tbl[0] = '{4'b0001,  4, 0, 0, 0};
        tbl[1] = '{4'b0010,  8, 0, 0, 0};
        tbl[2] = '{4'b0100, 20, 1, 0, 0};
        tbl[3] = '{4'b1000, 28, 1, 0, 0};
        tbl[4] = '{4'b0011, 40, 1, 1, 0};
        tbl[5] = '{4'b1100, 92, 1, 1, 3};
        tbl[6] = '{4'b1111, 20, 1, 0, 0};

        bus.i_drv_sw = 4'hF;
        repeat (3) @(negedge i_clk);
        chk("reset_press",  bus.o_press, 0);
        chk("reset_click",  bus.o_click, 0);
        chk("reset_toggle", bus.o_toggle, 0);
        chk("reset_long",   {bus.o_long, bus.o_repeat, bus.o_release}, 0);
        chk("reset_misc",   {bus.o_toggle_common, bus.o_code_valid, bus.o_code}, 0);
        i_rst = 1'b1;
        chk_en = 1'b1;

        // clean press on ch0, first click latency and long-press timing
        bus.i_drv_sw[0] = 1'b0;
        wait_pulse(0, 0, 20, "clean_click");
        chk("clean_code",   bus.o_code, 0);
        chk("clean_valid",  bus.o_code_valid, 1);
        chk("clean_toggle", bus.o_toggle, 4'b0001);
        chk("clean_common", bus.o_toggle_common, 0);
        @(negedge i_clk);
        chk("click_width",   bus.o_click[0], 0);
        chk("common_follow", bus.o_toggle_common, 1);
        n = 0;
        repeat (30) begin @(negedge i_clk); n += bus.o_long[0]; end
        chk("no_early_long", n, 0);
        @(negedge i_clk);
        chk("long_at_32", bus.o_long[0], 1);
        bus.i_drv_sw[0] = 1'b1;
        wait_pulse(2, 0, 20, "clean_release");
        repeat (40) @(negedge i_clk);

        // second click on ch0 toggles back
        bus.i_drv_sw[0] = 1'b0;
        wait_pulse(0, 0, 20, "toggle_click2");
        chk("toggle_back",    bus.o_toggle[0], 0);
        chk("common_lag",     bus.o_toggle_common, 1);
        @(negedge i_clk);
        chk("common_cleared", bus.o_toggle_common, 0);
        bus.i_drv_sw[0] = 1'b1;
        wait_pulse(2, 0, 20, "toggle_release");
        repeat (40) @(negedge i_clk);

        // bouncing ch1
        clear_counts();
        for (int k = 0; k < 40; k++) begin
            if (k % 3 == 0) bus.i_drv_sw[1] = ~bus.i_drv_sw[1];
            @(negedge i_clk);
        end
        chk("bounce_no_click", n_click[1], 0);
        bus.i_drv_sw[1] = 1'b0;
        wait_pulse(0, 1, 24, "bounce_settle_click");
        chk("bounce_code", bus.o_code, 1);
        repeat (20) @(negedge i_clk);
        chk("bounce_one_click", n_click[1], 1);
        bus.i_drv_sw[1] = 1'b1;
        wait_pulse(2, 1, 20, "bounce_release");
        repeat (40) @(negedge i_clk);

        // long hold on ch2
        bus.i_drv_sw[2] = 1'b0;
        wait_pulse(0, 2, 20, "hold_click");
        for (int c = 1; c <= 150; c++) begin
            @(negedge i_clk);
            chk("hold_long",   bus.o_long[2], c == 32);
            chk("hold_repeat", bus.o_repeat[2], c > 32 && (c - 32) % 16 == 0);
        end
        clear_counts();
        bus.i_drv_sw[2] = 1'b1;
        wait_pulse(2, 2, 20, "hold_release");
        r0 = n_rep[2];
        repeat (40) @(negedge i_clk);
        chk("hold_one_release",   n_rel[2], 1);
        chk("hold_no_rep_after",  n_rep[2], r0);

        // simultaneous ch1 + ch3
        bus.i_drv_sw = 4'b0101;
        wait_pulse(0, 1, 20, "simul_click");
        chk("simul_clicks", bus.o_click, 4'b1010);
        chk("simul_code",   bus.o_code, 1);
        chk("simul_toggle", bus.o_toggle, 4'b1100);
        @(negedge i_clk);
        chk("simul_common", bus.o_toggle_common, 1);
        bus.i_drv_sw = 4'hF;
        wait_pulse(2, 1, 20, "simul_release");
        repeat (40) @(negedge i_clk);

        // reset during LONG on ch2, key kept pressed through reset
        bus.i_drv_sw[2] = 1'b0;
        wait_pulse(0, 2, 20, "rst_click");
        wait_pulse(1, 2, 40, "rst_long");
        repeat (5) @(negedge i_clk);
        #3 i_rst = 1'b0;
        #1;
        chk("async_press",  bus.o_press, 0);
        chk("async_toggle", bus.o_toggle, 0);
        chk("async_pulses", {bus.o_click, bus.o_long, bus.o_repeat, bus.o_release}, 0);
        chk("async_misc",   {bus.o_toggle_common, bus.o_code_valid}, 0);
        @(negedge i_clk);
        i_rst = 1'b1;
        wait_pulse(0, 2, 20, "rst_fresh_click");
        chk("rst_toggle", bus.o_toggle, 4'b0100);
        for (int c = 1; c <= 32; c++) begin
            @(negedge i_clk);
            chk("rst_long_timing", bus.o_long[2], c == 32);
        end
        bus.i_drv_sw = 4'hF;

        // pulse-count table
        for (int t = 0; t < 7; t++) begin
            repeat (60) @(negedge i_clk);
            clear_counts();
            bus.i_drv_sw = ~tbl[t].mask;
            repeat (tbl[t].dur) @(negedge i_clk);
            bus.i_drv_sw = 4'hF;
            repeat (60) @(negedge i_clk);
            for (int c = 0; c < 4; c++) begin
                chk($sformatf("tbl%0d_click%0d", t, c),   n_click[c], tbl[t].mask[c] ? tbl[t].e_click : 0);
                chk($sformatf("tbl%0d_release%0d", t, c), n_rel[c],   tbl[t].mask[c] ? tbl[t].e_click : 0);
                chk($sformatf("tbl%0d_long%0d", t, c),    n_long[c],  tbl[t].mask[c] ? tbl[t].e_long : 0);
                chk($sformatf("tbl%0d_repeat%0d", t, c),  n_rep[c],   tbl[t].mask[c] ? tbl[t].e_rep : 0);
            end
        end

        // random pin activity, checked by the model every clock
        for (int it = 0; it < 150; it++) begin
            bus.i_drv_sw = 4'($urandom_range(0, 15));
            repeat ($urandom_range(1, 80)) @(negedge i_clk);
        end
        bus.i_drv_sw = 4'hF;
        repeat (60) @(negedge i_clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
